// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: control-word bit positions,
// access size / write-back select encodings and the memory-port FSM states.
package mem_pkg;

    localparam int CW_MEM_RD    = 6;
    localparam int CW_MEM_WR    = 5;
    localparam int CW_SIZE_HI   = 4;
    localparam int CW_SIZE_LO   = 3;
    localparam int CW_UNSIGNED  = 2;
    localparam int CW_WB_SEL_HI = 1;
    localparam int CW_WB_SEL_LO = 0;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        WB_NONE = 2'b00,
        WB_ALU  = 2'b01,
        WB_LOAD = 2'b10,
        WB_NPC4 = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_WAIT_GNT = 2'b01,
        S_WAIT_RV  = 2'b10
    } state_e;

    // Natural alignment check; the reserved size encoding never aligns.
    function automatic logic is_aligned(input size_e size, input logic [1:0] lsb);
        case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~lsb[0];
            SIZE_WORD: return lsb == 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a 32-bit read word and zero- or
// sign-extends it to a full register value.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lsb,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*lsb +: 8];
        half_sel = lsb[1] ? rdata[31:16] : rdata[15:0];
        case (size_e'(size))
            SIZE_BYTE: data = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
            SIZE_HALF: data = {{16{~load_unsigned & half_sel[15]}}, half_sel};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/register_generic.sv
// Enabled D register with asynchronous active-low reset to a fixed value.
module register_generic #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the req/gnt/rvalid data port, stalls upstream
// while an access is outstanding and owns the MEM/WB pipeline register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] ALUres,
    input  logic [N-1:0] wrData,
    input  logic [6:0]   cwMEM,
    input  logic [4:0]   Rdest,
    input  logic [N-1:0] NPC4_OUT,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [N-1:0] dmem_addr,
    output logic [3:0]   dmem_be,
    output logic [N-1:0] dmem_wdata,
    input  logic         dmem_gnt,
    input  logic         dmem_rvalid,
    input  logic [N-1:0] dmem_rdata,
    output logic         stall,
    output logic         misalign,
    output logic [N-1:0] wbData,
    output logic [4:0]   RdestWB,
    output logic         regWriteWB
);

    logic    mem_rd;
    logic    mem_wr;
    logic    load_unsigned;
    size_e   size;
    wb_sel_e wb_sel;
    logic    mem_op;
    logic    access;
    logic    misalign_raw;

    assign mem_rd        = cwMEM[CW_MEM_RD];
    assign mem_wr        = cwMEM[CW_MEM_WR];
    assign load_unsigned = cwMEM[CW_UNSIGNED];
    assign size          = size_e'(cwMEM[CW_SIZE_HI:CW_SIZE_LO]);
    assign wb_sel        = wb_sel_e'(cwMEM[CW_WB_SEL_HI:CW_WB_SEL_LO]);
    assign mem_op        = mem_rd | mem_wr;
    assign access        = mem_op & is_aligned(size, ALUres[1:0]);

    state_e state;
    state_e state_next;
    logic   req_raw;
    logic   complete;
    logic   stall_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (access) begin
                    if (!dmem_gnt) begin
                        state_next = S_WAIT_GNT;
                    end else if (!mem_wr) begin
                        state_next = S_WAIT_RV;
                    end
                end
            end
            S_WAIT_GNT: begin
                if (dmem_gnt) begin
                    state_next = mem_wr ? S_IDLE : S_WAIT_RV;
                end
            end
            S_WAIT_RV: begin
                if (dmem_rvalid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_raw      = 1'b0;
        complete     = 1'b0;
        misalign_raw = 1'b0;
        case (state)
            S_IDLE: begin
                req_raw      = access;
                complete     = access & mem_wr & dmem_gnt;
                misalign_raw = mem_op & ~access;
            end
            S_WAIT_GNT: begin
                req_raw  = 1'b1;
                complete = mem_wr & dmem_gnt;
            end
            S_WAIT_RV: begin
                complete = dmem_rvalid;
            end
            default: ;
        endcase
        stall_raw = ((state != S_IDLE) | access) & ~complete;
    end

    // Reset masks the port and pipeline controls at once, even mid-access.
    assign dmem_req = rst & req_raw;
    assign stall    = rst & stall_raw;
    assign misalign = rst & misalign_raw;

    assign dmem_we   = mem_wr;
    assign dmem_addr = {ALUres[N-1:2], 2'b00};

    always_comb begin
        case (size)
            SIZE_BYTE: begin
                dmem_be    = 4'b0001 << ALUres[1:0];
                dmem_wdata = {4{wrData[7:0]}};
            end
            SIZE_HALF: begin
                dmem_be    = 4'b0011 << ALUres[1:0];
                dmem_wdata = {2{wrData[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = wrData;
            end
        endcase
    end

    logic [N-1:0] load_data;
    logic [N-1:0] wb_next;
    logic         reg_write_next;
    logic         retire;

    load_align u_load_align (
        .rdata         (dmem_rdata),
        .lsb           (ALUres[1:0]),
        .size          (cwMEM[CW_SIZE_HI:CW_SIZE_LO]),
        .load_unsigned (load_unsigned),
        .data          (load_data)
    );

    always_comb begin
        case (wb_sel)
            WB_LOAD: wb_next = load_data;
            WB_NPC4: wb_next = NPC4_OUT;
            default: wb_next = ALUres;
        endcase
    end

    // A stalled cycle retires nothing: the register takes a bubble instead.
    assign retire         = ~stall_raw;
    assign reg_write_next = retire & (wb_sel != WB_NONE) & (Rdest != 5'd0) & ~misalign_raw;

    register_generic #(.WIDTH(N)) u_wb_data (
        .clk (clk),
        .rst (rst),
        .en  (retire),
        .d   (wb_next),
        .q   (wbData)
    );

    register_generic #(.WIDTH(5)) u_rdest (
        .clk (clk),
        .rst (rst),
        .en  (retire),
        .d   (Rdest),
        .q   (RdestWB)
    );

    register_generic #(.WIDTH(1)) u_reg_write (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (reg_write_next),
        .q   (regWriteWB)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage with a behavioural memory responder.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUres, wrData, NPC4_OUT, dmem_addr, dmem_wdata, dmem_rdata, wbData;
    logic [6:0]  cwMEM;
    logic [4:0]  Rdest, RdestWB;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, stall, misalign, regWriteWB;
    logic [3:0]  dmem_be;

    always #5 clk = ~clk;

    mem_stage #(.N(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ALUres      (ALUres),
        .wrData      (wrData),
        .cwMEM       (cwMEM),
        .Rdest       (Rdest),
        .NPC4_OUT    (NPC4_OUT),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .stall       (stall),
        .misalign    (misalign),
        .wbData      (wbData),
        .RdestWB     (RdestWB),
        .regWriteWB  (regWriteWB)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } wb_t;

    wb_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] a,
                                             input int sz, input logic uns);
        logic [31:0] sh;
        sh = rdata >> (8 * a);
        if (sz == 0) return uns ? (sh & 32'hFF) : 32'($signed(sh[7:0]));
        if (sz == 1) return uns ? (sh & 32'hFFFF) : 32'($signed(sh[15:0]));
        return rdata;
    endfunction

    // One instruction through the stage; g = cycles before gnt, r = cycles from gnt to rvalid.
    task automatic issue(input logic [6:0] cw, input logic [31:0] alu, input logic [31:0] wdat,
                         input logic [31:0] npc, input logic [31:0] rdat, input logic [4:0] rd,
                         input int g, input int r);
        int          sz   = int'(cw[4:3]);
        logic        mem  = cw[6] | cw[5];
        logic        wr   = cw[5];
        logic [1:0]  a    = alu[1:0];
        logic        ok   = (sz == 0) || (sz == 1 && a[0] == 1'b0) || (sz == 2 && a == 2'b00);
        logic        acc  = mem && ok;
        int          last = !acc ? 0 : (wr ? g : g + r);
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic        real_rv;
        wb_t         e;

        case (sz)
            0:       begin exp_be = 4'(1 << a); exp_wd = wdat[7:0] * 32'h0101_0101;  end
            1:       begin exp_be = 4'(3 << a); exp_wd = wdat[15:0] * 32'h0001_0001; end
            default: begin exp_be = 4'hF;       exp_wd = wdat;                       end
        endcase

        case (cw[1:0])
            2'b01:   e.data = alu;
            2'b10:   e.data = ref_load(rdat, a, sz, cw[2]);
            2'b11:   e.data = npc;
            default: e.data = 32'h0;
        endcase
        e.rd = rd;
        e.we = (cw[1:0] != 2'b00) && (rd != 5'd0) && !(mem && !ok);
        sb.push_back(e);

        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            ALUres   = alu;
            wrData   = wdat;
            NPC4_OUT = npc;
            cwMEM    = cw;
            Rdest    = rd;
            dmem_gnt = acc && (c == g);
            real_rv  = acc && !wr && (c == g + r);
            // Stray rvalid outside WAIT_RV must be ignored by the stage.
            dmem_rvalid = real_rv || ((!acc || c < g) && ($urandom_range(0, 3) == 0));
            dmem_rdata  = real_rv ? rdat : $urandom;
            #1;
            check("stall", stall, acc && (c != last));
            check("dmem_req", dmem_req, acc && (c <= g));
            check("misalign", misalign, mem && !ok);
            if (acc && c <= g) begin
                check("dmem_addr", dmem_addr, alu & 32'hFFFF_FFFC);
                check("dmem_we", dmem_we, wr);
                if (wr) begin
                    check("dmem_be", dmem_be, exp_be);
                    check("dmem_wdata", dmem_wdata, exp_wd);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic s;
        logic r0;
        wb_t  e;
        forever begin
            @(negedge clk);
            #2;
            s  = stall;
            r0 = rst;
            @(posedge clk);
            #1;
            if (r0 && rst) begin
                if (!s) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_underflow: retire seen, no expected entry (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        check("regWriteWB", regWriteWB, e.we);
                        check("RdestWB", RdestWB, e.rd);
                        if (e.we) check("wbData", wbData, e.data);
                    end
                end else begin
                    check("bubble_regWriteWB", regWriteWB, 1'b0);
                end
            end
        end
    end

    initial begin : driver
        logic [6:0]  cw;
        logic [31:0] alu, wd, npc, rdat;
        logic [4:0]  rd;
        logic [1:0]  sz, wbs;
        logic        uns;
        int          g, r, kind;

        rst = 1'b0;
        ALUres = 32'h100; wrData = '0; NPC4_OUT = '0; Rdest = 5'd1;
        cwMEM = 7'b1010010;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_wbData", wbData, 32'h0);
        check("rst_RdestWB", RdestWB, 5'd0);
        check("rst_regWriteWB", regWriteWB, 1'b0);
        cwMEM = 7'b0;
        @(posedge clk);
        #3 rst = 1'b1;

        issue(7'b0000001, 32'h1234, 32'h0, 32'h0, 32'h0, 5'd5, 0, 1);
        check("alu_wbData", wbData, 32'h0000_1234);
        check("alu_RdestWB", RdestWB, 5'd5);
        check("alu_regWriteWB", regWriteWB, 1'b1);

        issue(7'b0100000, 32'h103, 32'hAB, 32'h0, 32'h0, 5'd0, 0, 1);
        issue(7'b1001010, 32'h102, 32'h0, 32'h0, 32'h8001_0000, 5'd7, 2, 1);
        check("lh_wbData", wbData, 32'hFFFF_8001);
        issue(7'b1000110, 32'h101, 32'h0, 32'h0, 32'h0000_F000, 5'd9, 0, 1);
        check("lbu_wbData", wbData, 32'h0000_00F0);
        issue(7'b1010010, 32'h102, 32'h0, 32'h0, 32'h0, 5'd3, 0, 1);
        check("mis_regWriteWB", regWriteWB, 1'b0);

        // Reset while waiting for read data.
        @(negedge clk);
        ALUres = 32'h200; cwMEM = 7'b1010010; Rdest = 5'd8;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
        #1;
        check("rv_req", dmem_req, 1'b1);
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        check("rv_stall", stall, 1'b1);
        check("rv_req_low", dmem_req, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("midrst_req", dmem_req, 1'b0);
        check("midrst_stall", stall, 1'b0);
        check("midrst_regWriteWB", regWriteWB, 1'b0);
        check("midrst_wbData", wbData, 32'h0);
        @(negedge clk);
        cwMEM = 7'b0;
        @(posedge clk);
        #3 rst = 1'b1;

        issue(7'b1010010, 32'h200, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd4, 1, 2);
        check("restart_wbData", wbData, 32'hCAFE_F00D);
        issue(7'b0000011, 32'h0, 32'h0, 32'h0000_0404, 32'h0, 5'd1, 0, 1);
        issue(7'b0101001, 32'h102, 32'h1234_BEEF, 32'h0, 32'h0, 5'd2, 2, 1);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 4);
            alu  = $urandom; wd = $urandom; npc = $urandom; rdat = $urandom;
            rd   = 5'($urandom);
            g    = $urandom_range(0, 3);
            r    = $urandom_range(1, 3);
            uns  = 1'($urandom);
            sz   = 2'($urandom_range(0, 2));
            if (sz == 2'd1) alu[0] = 1'b0;
            if (sz == 2'd2) alu[1:0] = 2'b00;
            case (kind)
                0, 1: begin
                    wbs = 2'($urandom_range(0, 2));
                    if (wbs == 2'd2) wbs = 2'd3;
                    cw = {2'b00, 2'($urandom), uns, wbs};
                end
                2: cw = {2'b01, sz, uns, 1'b0, 1'($urandom)};
                3: cw = {2'b10, sz, uns, 2'b10};
                default: begin
                    sz = 2'($urandom_range(1, 3));
                    if (sz == 2'd1) alu[0] = 1'b1;
                    if (sz == 2'd2) alu[1:0] = 2'($urandom_range(1, 3));
                    cw = {($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10, sz, uns, 2'($urandom)};
                end
            endcase
            issue(cw, alu, wd, npc, rdat, rd, g, r);
        end

        #2;
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V Lite core. It sits directly downstream of the execute stage and consumes its EX/MEM register outputs: ALU result, store data, memory control word, destination register and link address. It drives a req/gnt/rvalid data-memory port, aligns and extends load data, and stalls the pipeline while an access is outstanding. It owns the MEM/WB pipeline register and the write-back forwarding value.

## Interface
- N, 32: datapath width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- ALUres  in  N  effective address, or the ALU write-back value.
- wrData  in  N  store data (unaligned, in the low bits).
- cwMEM  in  7  control word:
  - [6] mem_rd
  - [5] mem_wr
  - [4:3] size: 00 byte, 01 half, 10 word
  - [2] load_unsigned
  - [1:0] wb_sel: 00 none, 01 ALU, 10 load, 11 NPC4
- Rdest  in  5  destination register.
- NPC4_OUT  in  N  link address (PC+4).
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  N  word-aligned address ({ALUres[N-1:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  N  lane-replicated store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  N  read data.
- stall  out  1  freezes all upstream pipeline registers (drives pipe_en low).
- misalign  out  1  one-cycle pulse on a misaligned access.
- wbData  out  N  registered write-back value; also fed back to execute as muxOut_fwd.
- RdestWB  out  5  registered destination register.
- regWriteWB  out  1  registered write enable.

## Operation
- An access is valid when mem_rd or mem_wr is set and the address is aligned for its size:
  - half requires addr[0]=0.
  - word requires addr[1:0]=00.
  - size 11 counts as misaligned.
- Misaligned access:
  - no request is issued and misalign pulses;
  - the instruction retires with regWriteWB=0.
- Store lanes:
  - byte: be=0001<<addr[1:0], wdata={4{wrData[7:0]}}.
  - half: be=0011<<addr[1:0], wdata={2{wrData[15:0]}}.
  - word: be=1111, wdata=wrData.
- Load extraction:
  - select the byte or half by addr[1:0];
  - sign-extend unless load_unsigned is set.
- wb_sel picks the write-back value: ALUres, the extracted load, or NPC4_OUT.
- regWriteWB = (wb_sel≠00) & (Rdest≠0) & retiring & no misalign.
- FSM states:
  - IDLE:
    - a valid access asserts dmem_req combinationally.
    - gnt on a write: the access completes this cycle; stay in IDLE.
    - gnt on a read: go to WAIT_RV.
    - no gnt: go to WAIT_GNT.
  - WAIT_GNT:
    - req is held with addr/we/be/wdata stable until gnt.
    - then: writes go to IDLE, reads go to WAIT_RV.
  - WAIT_RV:
    - req is low; leave on rvalid, capturing the load, then go to IDLE.
- stall=1 whenever an access is valid and not completing this cycle. Completion means:
  - write: gnt is seen;
  - read: rvalid is seen in WAIT_RV.
- MEM/WB register:
  - while stall=1 it loads a bubble (regWriteWB=0; wbData and RdestWB hold).
  - otherwise it captures the retiring instruction.
- Simultaneous gnt and rvalid in IDLE: not allowed. rvalid is valid only in WAIT_RV; rvalid in any other state is ignored.

## Timing
- Reset state: FSM in IDLE; stall, dmem_req and misalign are 0; wbData=0, RdestWB=0, regWriteWB=0.
- Reset asserted mid-access drops req immediately. The memory side must discard any pending response.
- Non-memory instruction: one cycle through the stage; the result is visible in MEM/WB after the next edge.
- Write with gnt in the same cycle: zero stall cycles.
- Read: at least one stall cycle. Total stall cycles = cycles until gnt + cycles from gnt to rvalid.
- stall is combinational from state, gnt and rvalid. The dmem_* outputs do not depend combinationally on rvalid.
- Load data is registered into wbData on the rvalid edge. The next instruction enters the stage on that same edge.

## Structure
- The shared package mem_pkg holds:
  - the cwMEM bit-index constants;
  - the size and wb_sel enums;
  - the FSM state enum.
- A single sub-module, load_align, is natural: a combinational unit taking rdata, addr[1:0], size and unsigned, and producing the extended word.
- MEM/WB storage uses register_generic instances.

## Test plan
- ALU op: wb_sel=01, ALUres=0x1234, Rdest=5 → after one edge wbData=0x1234, RdestWB=5, regWriteWB=1, stall never high.
- Store byte: addr=0x103, wrData=0xAB, gnt immediate → be=1000, wdata=0xABABABAB, stall=0.
- Load half, signed: addr=0x102, gnt after 2 cycles, rvalid 1 cycle later, rdata=0x8001_0000 → 3 stall cycles; wbData=0xFFFF8001.
- Load byte, unsigned: addr=0x101, rdata=0x0000_F000 → wbData=0x000000F0.
- Misaligned word load at 0x102 → no req; misalign for 1 cycle; regWriteWB=0; stall=0.
- Reset during WAIT_RV → req/stall at 0 immediately; regWriteWB=0; FSM restarts cleanly on the next access.
